instr_program_loader: RTL and testbench

Sequential RISC-V instruction encoder and program writer, the encoding counterpart of the core's instruction control decoder. It accepts one symbolic instruction per handshake (mnemonic, register indices, immediate), packs it into a 32-bit RV32I word and writes the words sequentially into instruction memory starting at a base address. It sits beside instruction memory and fills it before the core is released from reset.

---
 rtl/rv_isa_pkg.sv | 81 ++++++++
 rtl/instr_encoder.sv | 36 +++
 rtl/instr_program_loader.sv | 172 +++++++++++++++++
 tb/tb_instr_program_loader.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants, mnemonic codes and loader state encoding shared by
// the instruction program loader and its encoder.
package rv_isa_pkg;

  localparam int unsigned MNEM_W = 4;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned IMM_W  = 13;
  localparam int unsigned WORD_W = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL     = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_LB      = 3'b000;
  localparam logic [2:0] F3_SB      = 3'b000;
  localparam logic [2:0] F3_BEQ     = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Symbolic mnemonic codes; 13..15 are illegal.
  typedef enum logic [MNEM_W-1:0] {
    MN_ADD  = 4'd0,
    MN_SUB  = 4'd1,
    MN_AND  = 4'd2,
    MN_OR   = 4'd3,
    MN_SLT  = 4'd4,
    MN_XOR  = 4'd5,
    MN_SRL  = 4'd6,
    MN_ADDI = 4'd7,
    MN_ANDI = 4'd8,
    MN_ORI  = 4'd9,
    MN_LB   = 4'd10,
    MN_SB   = 4'd11,
    MN_BEQ  = 4'd12
  } mnem_e;

  // Loader states; READ and CHECK are only reachable with readback enabled.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_WRITE  = 3'd2,
    ST_READ   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_FINISH = 3'd5
  } state_e;

  function automatic logic [WORD_W-1:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                              input logic [4:0] rs1, input logic [2:0] f3,
                                              input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [WORD_W-1:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                              input logic [2:0] f3, input logic [4:0] rd,
                                              input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [WORD_W-1:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                              input logic [4:0] rs1, input logic [2:0] f3,
                                              input logic [6:0] op);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], op};
  endfunction

  // boff holds branch offset bits [12:1]; bit 0 of the offset is implicitly zero.
  function automatic logic [WORD_W-1:0] enc_b(input logic [11:0] boff, input logic [4:0] rs2,
                                              input logic [4:0] rs1, input logic [2:0] f3,
                                              input logic [6:0] op);
    return {boff[11], boff[9:4], rs2, rs1, f3, boff[3:0], boff[10], op};
  endfunction

endpackage

// File: rtl/instr_encoder.sv
// Combinational packer from symbolic instruction fields to an RV32I word.
module instr_encoder
  import rv_isa_pkg::*;
(
  input  logic [MNEM_W-1:0] mnem,
  input  logic [REG_W-1:0]  rd,
  input  logic [REG_W-1:0]  rs1,
  input  logic [REG_W-1:0]  rs2,
  input  logic [IMM_W-1:0]  imm,
  output logic [WORD_W-1:0] word_c,
  output logic              illegal_c
);

  // Select format and function codes per mnemonic; unused fields stay zero.
  always_comb begin
    word_c    = '0;
    illegal_c = 1'b0;
    case (mnem)
      MN_ADD:  word_c = enc_r(F7_BASE, rs2, rs1, F3_ADD_SUB, rd, OP_R);
      MN_SUB:  word_c = enc_r(F7_ALT,  rs2, rs1, F3_ADD_SUB, rd, OP_R);
      MN_AND:  word_c = enc_r(F7_BASE, rs2, rs1, F3_AND,     rd, OP_R);
      MN_OR:   word_c = enc_r(F7_BASE, rs2, rs1, F3_OR,      rd, OP_R);
      MN_SLT:  word_c = enc_r(F7_BASE, rs2, rs1, F3_SLT,     rd, OP_R);
      MN_XOR:  word_c = enc_r(F7_BASE, rs2, rs1, F3_XOR,     rd, OP_R);
      MN_SRL:  word_c = enc_r(F7_BASE, rs2, rs1, F3_SRL,     rd, OP_R);
      MN_ADDI: word_c = enc_i(imm[11:0], rs1, F3_ADD_SUB, rd, OP_IMM);
      MN_ANDI: word_c = enc_i(imm[11:0], rs1, F3_AND,     rd, OP_IMM);
      MN_ORI:  word_c = enc_i(imm[11:0], rs1, F3_OR,      rd, OP_IMM);
      MN_LB:   word_c = enc_i(imm[11:0], rs1, F3_LB,      rd, OP_LOAD);
      MN_SB:   word_c = enc_s(imm[11:0], rs2, rs1, F3_SB, OP_STORE);
      MN_BEQ:  word_c = enc_b(imm[12:1], rs2, rs1, F3_BEQ, OP_BRANCH);
      default: illegal_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_program_loader.sv
// Sequential program writer: encodes one instruction per handshake and writes
// the words to consecutive instruction-memory addresses from BASE_ADDR.
// Optional write-verify pass enabled by defining LOADER_READBACK_EN.
module instr_program_loader
  import rv_isa_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_last,
  input  logic [MNEM_W-1:0] in_mnem,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_rs1,
  input  logic [REG_W-1:0]  in_rs2,
  input  logic [IMM_W-1:0]  in_imm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ADDR_BASE = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  logic [WORD_W-1:0]   enc_word_c;
  logic                enc_illegal_c;
  logic                start_accept_c;
  logic                beat_accept_c;
  logic                beat_exit_c;
  logic                at_end_c;
  logic                rb_mismatch_c;

  instr_encoder u_encoder (
    .mnem      (in_mnem),
    .rd        (in_rd),
    .rs1       (in_rs1),
    .rs2       (in_rs2),
    .imm       (in_imm),
    .word_c    (enc_word_c),
    .illegal_c (enc_illegal_c)
  );

  assign start_accept_c = (state_q == ST_IDLE) && start;
  assign beat_accept_c  = in_valid && in_ready_q;
  assign at_end_c       = last_q || (addr_q == ADDR_LAST);

`ifdef LOADER_READBACK_EN
  assign beat_exit_c   = (state_q == ST_CHECK);
  assign rb_mismatch_c = (mem_rdata != word_q);
`else
  logic unused_rdata;
  assign beat_exit_c   = (state_q == ST_WRITE);
  assign rb_mismatch_c = 1'b0;
  assign unused_rdata  = ^mem_rdata;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_ACCEPT;
      ST_ACCEPT: begin
        if (beat_accept_c) begin
          if (!enc_illegal_c) state_d = ST_WRITE;
          else if (in_last)   state_d = ST_FINISH;
        end
      end
`ifdef LOADER_READBACK_EN
      ST_WRITE:  state_d = ST_READ;
      ST_READ:   state_d = ST_CHECK;
      ST_CHECK:  state_d = at_end_c ? ST_FINISH : ST_ACCEPT;
`else
      ST_WRITE:  state_d = at_end_c ? ST_FINISH : ST_ACCEPT;
`endif
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; strobes are decoded from the next state
  // so that they are registered and aligned with the state they belong to.
  always_comb begin
    addr_d     = addr_q;
    word_d     = word_q;
    last_d     = last_q;
    err_d      = err_q;
    in_ready_d = (state_d == ST_ACCEPT);
    mem_we_d   = (state_d == ST_WRITE);
    done_d     = (state_d == ST_FINISH);
    busy_d     = (state_d != ST_IDLE);

    if (start_accept_c) begin
      addr_d = ADDR_BASE;
      err_d  = 1'b0;
    end

    if (beat_accept_c) begin
      if (enc_illegal_c) begin
        err_d = 1'b1;
      end else begin
        word_d = enc_word_c;
        last_d = in_last;
      end
    end

    if (beat_exit_c) begin
      if (rb_mismatch_c) err_d = 1'b1;
      // Reaching the top address without last is an overflow; no wrap.
      if (at_end_c) begin
        if (!last_q) err_d = 1'b1;
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q     <= ADDR_BASE;
      word_q     <= '0;
      last_q     <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      word_q     <= word_d;
      last_q     <= last_d;
      err_q      <= err_d;
      in_ready_q <= in_ready_d;
      mem_we_q   <= mem_we_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = word_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_instr_program_loader.sv
// Scoreboard bench for instr_program_loader: a reference model predicts the
// memory writes and the error flag of each program; a monitor checks them.
module tb_instr_program_loader;

  localparam int unsigned ADDR_W    = 4;
  localparam int unsigned BASE_ADDR = 0;
  localparam int unsigned NWORDS    = 1 << ADDR_W;
  localparam int unsigned ADDR_MAX  = NWORDS - 1;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              in_last = 1'b0;
  logic [3:0]        in_mnem = '0;
  logic [4:0]        in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [12:0]       in_imm = '0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              busy, done, err;

  instr_program_loader #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_last(in_last), .in_mnem(in_mnem), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned mn, rd, rs1, rs2, imm;
    bit          last;
  } beat_t;

  typedef struct {
    int unsigned addr;
    logic [31:0] data;
  } wr_t;

  int   checks = 0;
  int   errors = 0;
  wr_t  wq[$];
  bit   dq[$];
  bit   sb_en = 1'b1;
  logic [31:0] mem [NWORDS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Instruction memory with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  // Monitor: every write and every done pulse is matched against the queues.
  always @(negedge clk) begin
    wr_t w;
    bit  e;
    if (rst_n && sb_en) begin
      if (mem_we) begin
        if (wq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data 0x%08h", mem_addr, mem_wdata);
        end else begin
          w = wq.pop_front();
          chk("wr_addr", 32'(mem_addr), w.addr);
          chk("wr_data", mem_wdata, w.data);
        end
      end
      if (done) begin
        if (dq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: err %0d", err);
        end else begin
          e = dq.pop_front();
          chk("done_err", 32'(err), 32'(e));
          chk("done_pending_writes", 32'(wq.size()), 32'd0);
        end
      end
    end
  end

  // Reference encoding built from the RV32I field positions.
  function automatic logic [31:0] ref_word(input beat_t b, output bit ill);
    int unsigned w, imm, f3;
    imm = b.imm & 32'h1FFF;
    ill = 1'b0;
    w   = 0;
    case (b.mn)
      0, 1, 2, 3, 4, 5, 6: begin
        case (b.mn)
          2: f3 = 7;
          3: f3 = 6;
          4: f3 = 2;
          5: f3 = 4;
          6: f3 = 5;
          default: f3 = 0;
        endcase
        w = 51 | (b.rd << 7) | (f3 << 12) | (b.rs1 << 15) | (b.rs2 << 20)
            | ((b.mn == 1) ? (32'd32 << 25) : 32'd0);
      end
      7, 8, 9: begin
        f3 = (b.mn == 7) ? 0 : (b.mn == 8) ? 7 : 6;
        w  = 19 | (b.rd << 7) | (f3 << 12) | (b.rs1 << 15) | ((imm & 4095) << 20);
      end
      10: w = 3 | (b.rd << 7) | (b.rs1 << 15) | ((imm & 4095) << 20);
      11: w = 35 | ((imm & 31) << 7) | (b.rs1 << 15) | (b.rs2 << 20) | (((imm >> 5) & 127) << 25);
      12: w = 99 | (((imm >> 11) & 1) << 7) | (((imm >> 1) & 15) << 8) | (b.rs1 << 15)
              | (b.rs2 << 20) | (((imm >> 5) & 63) << 25) | (((imm >> 12) & 1) << 31);
      default: ill = 1'b1;
    endcase
    return w;
  endfunction

  // Predict writes, final error flag and number of beats the loader takes.
  task automatic model_prog(input beat_t p[$], output int exp_acc);
    int unsigned addr;
    bit          e, ill;
    logic [31:0] w;
    addr    = BASE_ADDR;
    e       = 1'b0;
    exp_acc = 0;
    for (int i = 0; i < p.size(); i++) begin
      exp_acc++;
      w = ref_word(p[i], ill);
      if (ill) begin
        e = 1'b1;
        if (p[i].last) break;
      end else begin
        wq.push_back('{addr: addr, data: w});
        if (p[i].last) break;
        if (addr == ADDR_MAX) begin
          e = 1'b1;
          break;
        end
        addr++;
      end
    end
    dq.push_back(e);
  endtask

  function automatic beat_t mk(input int unsigned mn, rd, rs1, rs2, imm, input bit last);
    beat_t b;
    b.mn = mn; b.rd = rd; b.rs1 = rs1; b.rs2 = rs2; b.imm = imm; b.last = last;
    return b;
  endfunction

  task automatic drive_beat(input beat_t b);
    in_mnem  = 4'(b.mn);
    in_rd    = 5'(b.rd);
    in_rs1   = 5'(b.rs1);
    in_rs2   = 5'(b.rs2);
    in_imm   = 13'(b.imm);
    in_last  = b.last;
    in_valid = 1'b1;
  endtask

  // Run one program; optionally pulse start mid-load, which must be ignored.
  task automatic run_prog(input beat_t p[$], input bit poke);
    int exp_acc, acc, budget;
    acc = 0;
    model_prog(p, exp_acc);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int i = 0; i < p.size(); i++) begin
      drive_beat(p[i]);
      if (poke && i == 1) start = 1'b1;
      budget = 50;
      while (!in_ready && busy && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (budget == 0) fail_now("beat_wait");
      if (!in_ready) begin
        in_valid = 1'b0;
        start    = 1'b0;
        break;
      end
      @(posedge clk);
      acc++;
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
      start    = 1'b0;
    end
    budget = 50;
    while (busy && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (budget == 0) fail_now("busy_drop");
    chk("accepted_beats", 32'(acc), 32'(exp_acc));
    chk("idle_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), BASE_ADDR);
  endtask

  initial begin
    beat_t p[$];
    int    budget, nwe, len;

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // in_valid without start is never accepted.
    drive_beat(mk(0, 3, 1, 2, 0, 1'b1));
    repeat (4) begin
      @(negedge clk);
      chk("nostart_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;

    p = {}; p.push_back(mk(0, 3, 1, 2, 0, 1'b1));
    run_prog(p, 1'b0);
    chk("golden_add", mem[0], 32'h002081B3);

    p = {}; p.push_back(mk(7, 5, 0, 0, 13'h1FFF, 1'b0)); p.push_back(mk(11, 0, 1, 2, 4, 1'b1));
    run_prog(p, 1'b1);
    chk("golden_addi", mem[0], 32'hFFF00293);
    chk("golden_sb", mem[1], 32'h00208223);

    p = {}; p.push_back(mk(12, 0, 1, 2, 13'h1FFC, 1'b1));
    run_prog(p, 1'b0);
    chk("golden_beq", mem[0], 32'hFE208EE3);

    p = {}; p.push_back(mk(0, 1, 2, 3, 0, 1'b0)); p.push_back(mk(14, 1, 1, 1, 0, 1'b0));
    p.push_back(mk(0, 4, 5, 6, 0, 1'b1));
    run_prog(p, 1'b0);
    chk("illegal_err_sticky", 32'(err), 32'd1);

    // Overflow: more beats than words, no last.
    p = {};
    for (int i = 0; i < NWORDS + 2; i++) p.push_back(mk(1, i % 32, 1, 2, 0, 1'b0));
    run_prog(p, 1'b0);

    // Reset during the second WRITE, then restart from the base address.
    sb_en = 1'b0;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    nwe = 0;
    for (int k = 0; k < 2; k++) begin
      drive_beat(mk(2, 7, 8, 9, 0, 1'b0));
      budget = 20;
      while (!in_ready && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      if (budget == 0) fail_now("rst_beat_wait");
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (mem_we) nwe++;
    end
    chk("rst_pre_write", 32'(nwe), 32'd2);
    chk("rst_pre_addr", 32'(mem_addr), BASE_ADDR + 1);
    #1 rst_n = 1'b0;
    #1 chk_all_zero("midrst");
    wq.delete();
    dq.delete();
    @(negedge clk) rst_n = 1'b1;
    sb_en = 1'b1;
    p = {}; p.push_back(mk(5, 10, 11, 12, 0, 1'b1));
    run_prog(p, 1'b0);

    // Randomised programs; some end early on a mid-stream last, some overflow.
    for (int t = 0; t < 25; t++) begin
      p   = {};
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++)
        p.push_back(mk($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 31), $urandom_range(0, 8191),
                       (i == len - 1) || ($urandom_range(0, 9) == 0)));
      run_prog(p, 1'($urandom_range(0, 1)));
    end

    chk("final_queue_writes", 32'(wq.size()), 32'd0);
    chk("final_queue_done", 32'(dq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
